// File: rtl/bus_irq_pkg.sv
// Shared constants and types for the bus interrupt controller.
// Register offsets, FSM states and priority mode selectors.
package bus_irq_pkg;

    localparam logic [7:0] OFS_MASK = 8'd0;
    localparam logic [7:0] OFS_PEND = 8'd1;
    localparam logic [7:0] OFS_VEC  = 8'd2;
    localparam logic [7:0] OFS_EOI  = 8'd3;
    localparam logic [7:0] OFS_SOFT = 8'd4;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

endpackage

// File: rtl/bus_irq_arbiter.sv
// Combinational winner selection over the candidate vector.
// Fixed mode picks the lowest index; round-robin starts after last grant.
module bus_irq_arbiter
    import bus_irq_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int PRIO_MODE = 0,
    parameter int ID_W      = 3
) (
    input  logic [N_SRC-1:0] i_cand,
    input  logic [ID_W-1:0]  i_last,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    // Scan candidates in priority order, first hit wins
    always_comb begin
        int idx;
        idx     = 0;
        o_valid = 1'b0;
        o_id    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (PRIO_MODE == PRIO_RR)
                idx = (int'(i_last) + k) % N_SRC;
            else
                idx = k - 1;
            if (!o_valid && i_cand[idx]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_irq_controller.sv
// Memory-mapped interrupt controller: N sources to one CPU request.
// Mask/pending/vector registers, EOI handshake, per-source ack pulses.
module bus_irq_controller
    import bus_irq_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         PRIO_MODE = 0,
    parameter int         ID_W      = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       BUS_ADDR,
    inout  wire  [7:0]       BUS_DATA,
    input  logic             BUS_WE,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic [N_SRC-1:0] IRQ_ACK_OUT,
    output logic             CPU_IRQ_RAISE,
    input  logic             CPU_IRQ_ACK
);

    state_t             r_state;
    state_t             w_next;
    logic [N_SRC-1:0]   r_irq_s;
    logic [N_SRC-1:0]   r_irq_d;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pend;
    logic [N_SRC-1:0]   r_ack;
    logic [ID_W-1:0]    r_cur;
    logic [ID_W-1:0]    r_last;
    logic [7:0]         r_rd_data;
    logic               r_rd_oe;

    logic [7:0]         w_ofs;
    logic               w_hit;
    logic               w_wr;
    logic               w_eoi;
    logic [N_SRC-1:0]   w_wdat;
    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_set;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_cur_oh;
    logic [7:0]         w_rd;
    logic               w_arb_valid;
    logic [ID_W-1:0]    w_arb_id;
    logic               w_latch;
    logic               w_grant;
    logic               w_unused;

    assign w_ofs   = BUS_ADDR - BASE_ADDR;
    assign w_hit   = (BUS_ADDR >= BASE_ADDR) && (w_ofs <= OFS_SOFT);
    assign w_wr    = w_hit && BUS_WE;
    assign w_eoi   = w_wr && (w_ofs == OFS_EOI);
    assign w_wdat  = BUS_DATA[N_SRC-1:0];
    assign w_edge  = r_irq_s & ~r_irq_d;
    assign w_unused = ^BUS_DATA;

    assign CPU_IRQ_RAISE = (r_state == REQ);
    assign IRQ_ACK_OUT   = r_ack;
    assign BUS_DATA      = r_rd_oe ? r_rd_data : 8'hzz;

    bus_irq_arbiter #(
        .N_SRC     (N_SRC),
        .PRIO_MODE (PRIO_MODE),
        .ID_W      (ID_W)
    ) u_arb (
        .i_cand  (r_pend & r_mask),
        .i_last  (r_last),
        .o_valid (w_arb_valid),
        .o_id    (w_arb_id)
    );

    // One-hot of the source currently being serviced
    always_comb begin
        w_cur_oh = '0;
        for (int i = 0; i < N_SRC; i++)
            w_cur_oh[i] = (int'(r_cur) == i);
    end

    // Pending set/clear sources; sets take priority over clears
    always_comb begin
        w_set = w_edge;
        w_clr = '0;
        if (w_wr && (w_ofs == OFS_SOFT))
            w_set = w_set | w_wdat;
        if (w_wr && (w_ofs == OFS_PEND))
            w_clr = w_clr | w_wdat;
        if (w_grant)
            w_clr = w_clr | w_cur_oh;
    end

    // Register read mux, unused bits read as zero
    always_comb begin
        w_rd = '0;
        unique case (w_ofs)
            OFS_MASK: w_rd[N_SRC-1:0] = r_mask;
            OFS_PEND: w_rd[N_SRC-1:0] = r_pend;
            OFS_VEC: begin
                w_rd[7]      = (r_state != IDLE);
                w_rd[ID_W-1:0] = r_cur;
            end
            default: w_rd = '0;
        endcase
    end

    // FSM next state: arbitrate, wait for CPU ack, wait for EOI
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_grant = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next  = REQ;
                    w_latch = 1'b1;
                end
            end
            REQ: begin
                if (CPU_IRQ_ACK) begin
                    w_next  = SERVICE;
                    w_grant = 1'b1;
                end
            end
            SERVICE: begin
                if (w_eoi)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Input capture, registers, grant bookkeeping and ack pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq_s <= '0;
            r_irq_d <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_ack   <= '0;
            r_cur   <= '0;
            r_last  <= ID_W'(N_SRC - 1);
        end else begin
            r_irq_s <= IRQ_IN;
            r_irq_d <= r_irq_s;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            r_ack   <= w_grant ? w_cur_oh : '0;
            if (w_wr && (w_ofs == OFS_MASK))
                r_mask <= w_wdat;
            if (w_latch)
                r_cur <= w_arb_id;
            if (w_grant)
                r_last <= r_cur;
        end
    end

    // Registered read data and bus drive enable
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_data <= '0;
            r_rd_oe   <= 1'b0;
        end else begin
            r_rd_oe   <= w_hit && !BUS_WE;
            r_rd_data <= w_rd;
        end
    end

endmodule

// File: tb/tb_bus_irq_controller.sv
// Bench for bus_irq_controller: fixed and round-robin instances share the bus.
// Random raise patterns are scored against a priority model of the grant order.
module tb_bus_irq_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    wire  [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [7:0] wdata;
    logic       wen;
    logic [3:0] irq_fx, irq_rr, ack_fx, ack_rr;
    logic       raise_fx, raise_rr, cack_fx, cack_rr;

    int errors = 0;
    int checks = 0;
    int last_rr = 3;

    localparam logic [7:0] FX = 8'hE0;
    localparam logic [7:0] RR = 8'hF0;

    assign BUS_DATA = wen ? wdata : 8'hzz;

    always #5 CLK = ~CLK;

    bus_irq_controller #(
        .N_SRC(4), .BASE_ADDR(8'hE0), .PRIO_MODE(0), .ID_W(3)
    ) u_fx (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE), .IRQ_IN(irq_fx),
        .IRQ_ACK_OUT(ack_fx), .CPU_IRQ_RAISE(raise_fx),
        .CPU_IRQ_ACK(cack_fx)
    );

    bus_irq_controller #(
        .N_SRC(4), .BASE_ADDR(8'hF0), .PRIO_MODE(1), .ID_W(3)
    ) u_rr (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE), .IRQ_IN(irq_rr),
        .IRQ_ACK_OUT(ack_rr), .CPU_IRQ_RAISE(raise_rr),
        .CPU_IRQ_ACK(cack_rr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a; wdata = d; wen = 1'b1; BUS_WE = 1'b1;
        tick();
        BUS_WE = 1'b0; wen = 1'b0; BUS_ADDR = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        BUS_ADDR = a; BUS_WE = 1'b0;
        tick();
        d = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    function automatic logic raise_of(input bit rr);
        return rr ? raise_rr : raise_fx;
    endfunction

    function automatic logic [3:0] ack_of(input bit rr);
        return rr ? ack_rr : ack_fx;
    endfunction

    // Reference priority rule: lowest index, or first after last grant
    function automatic int pick(input logic [3:0] p, input int last, input bit rr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = rr ? (last + 1 + k) % 4 : k;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_irq(input bit rr, input int id, input logic v);
        if (rr) irq_rr[id] = v;
        else irq_fx[id] = v;
    endtask

    task automatic do_service(input bit rr, input int id);
        logic [7:0] v;
        logic [7:0] base;
        logic [3:0] a;
        int n;
        base = rr ? RR : FX;
        n = 0;
        while (!raise_of(rr) && n < 20) begin tick(); n++; end
        checks++;
        if (raise_of(rr) !== 1'b1) begin
            errors++;
            $display("FAIL raise_timeout rr=%0d got=%b want=1", rr, raise_of(rr));
        end
        bus_read(base + 8'd2, v);
        checks++;
        if (v !== (8'h80 | 8'(id))) begin
            errors++;
            $display("FAIL vector rr=%0d got=%h want=%h", rr, v, 8'h80 | 8'(id));
        end
        if (rr) cack_rr = 1'b1; else cack_fx = 1'b1;
        tick();
        cack_rr = 1'b0; cack_fx = 1'b0;
        a = ack_of(rr);
        checks++;
        if (a !== (4'b0001 << id)) begin
            errors++;
            $display("FAIL ack_pulse rr=%0d got=%b want=%b", rr, a, 4'b0001 << id);
        end
        set_irq(rr, id, 1'b0);
        tick();
        a = ack_of(rr);
        checks++;
        if (a !== 4'b0000) begin
            errors++;
            $display("FAIL ack_width rr=%0d got=%b want=0000", rr, a);
        end
        bus_write(base + 8'd3, 8'h00);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        last_rr = 3;
        tick();
        for (int r = 0; r < 3; r++) begin
            bus_read(FX + 8'(r), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h want=00", r, v);
            end
        end
        checks++;
        if (raise_fx !== 1'b0 || ack_fx !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%b want=0/0000", raise_fx, ack_fx);
        end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        bus_write(FX, 8'h0F);
        irq_fx[2] = 1'b1;
        tick(); tick();
        checks++;
        if (raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got=%b want=0", raise_fx);
        end
        tick();
        checks++;
        if (raise_fx !== 1'b1) begin
            errors++;
            $display("FAIL latency_t3 got=%b want=1", raise_fx);
        end
        bus_read(FX + 8'd2, v);
        checks++;
        if (v !== 8'h82) begin
            errors++;
            $display("FAIL basic_vector got=%h want=82", v);
        end
        cack_fx = 1'b1;
        tick();
        cack_fx = 1'b0;
        checks++;
        if (ack_fx !== 4'b0100 || raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got=%b/%b want=0100/0", ack_fx, raise_fx);
        end
        irq_fx[2] = 1'b0;
        tick();
        checks++;
        if (ack_fx !== 4'b0000) begin
            errors++;
            $display("FAIL basic_ack_width got=%b want=0000", ack_fx);
        end
        bus_read(FX + 8'd1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL basic_pending got=%h want=00", v);
        end
        bus_write(FX + 8'd3, 8'h00);
        bus_read(FX + 8'd2, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL basic_eoi_vector got=%h want=02", v);
        end
    endtask

    task automatic test_fixed_prio();
        irq_fx[1] = 1'b1;
        irq_fx[3] = 1'b1;
        do_service(1'b0, 1);
        do_service(1'b0, 3);
    endtask

    task automatic test_round_robin();
        int want [4] = '{0, 1, 0, 1};
        bus_write(RR, 8'h03);
        irq_rr[0] = 1'b1;
        irq_rr[1] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            do_service(1'b1, want[r]);
            last_rr = want[r];
            if (r < 2) irq_rr[want[r]] = 1'b1;
        end
    endtask

    task automatic test_mask_w1c();
        logic [7:0] v;
        bus_write(FX, 8'h00);
        irq_fx[0] = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL masked_raise got=%b want=0", raise_fx);
        end
        bus_read(FX + 8'd1, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL masked_pending got=%h want=01", v);
        end
        bus_write(FX, 8'h01);
        checks++;
        if (raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL unmask_early got=%b want=0", raise_fx);
        end
        tick();
        checks++;
        if (raise_fx !== 1'b1) begin
            errors++;
            $display("FAIL unmask_raise got=%b want=1", raise_fx);
        end
        do_service(1'b0, 0);
        bus_write(FX, 8'h00);
        irq_fx[0] = 1'b1;
        tick();
        bus_write(FX + 8'd1, 8'h01);
        bus_read(FX + 8'd1, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL w1c_vs_set got=%h want=01", v);
        end
        irq_fx[0] = 1'b0;
        bus_write(FX + 8'd1, 8'hFF);
        bus_read(FX + 8'd1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL w1c_clear got=%h want=00", v);
        end
        bus_write(FX, 8'h0F);
    endtask

    task automatic test_soft_trig();
        logic [7:0] v;
        bus_write(FX + 8'd4, 8'h08);
        tick();
        checks++;
        if (raise_fx !== 1'b1) begin
            errors++;
            $display("FAIL soft_raise got=%b want=1", raise_fx);
        end
        do_service(1'b0, 3);
        bus_write(FX + 8'd3, 8'h00);
        tick();
        checks++;
        if (raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL idle_eoi_raise got=%b want=0", raise_fx);
        end
        bus_read(FX + 8'd2, v);
        checks++;
        if (v !== 8'h03) begin
            errors++;
            $display("FAIL idle_eoi_vector got=%h want=03", v);
        end
    endtask

    task automatic test_random(input bit rr);
        logic [3:0] mpend;
        logic [3:0] nw;
        logic [3:0] lines;
        logic [7:0] base;
        logic [7:0] v;
        int last;
        int exp;
        int n;
        base = rr ? RR : FX;
        last = rr ? last_rr : 0;
        bus_write(base, 8'h0F);
        mpend = 4'($urandom_range(1, 15));
        if (rr) irq_rr = mpend; else irq_fx = mpend;
        for (int r = 0; r < 30 && mpend != 4'b0; r++) begin
            exp = pick(mpend, last, rr);
            n = 0;
            while (!raise_of(rr) && n < 20) begin tick(); n++; end
            bus_read(base + 8'd2, v);
            checks++;
            if (v !== (8'h80 | 8'(exp))) begin
                errors++;
                $display("FAIL rand_grant rr=%0d round=%0d got=%h want=%h",
                         rr, r, v, 8'h80 | 8'(exp));
            end
            if (rr) cack_rr = 1'b1; else cack_fx = 1'b1;
            tick();
            cack_rr = 1'b0; cack_fx = 1'b0;
            checks++;
            if (ack_of(rr) !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL rand_ack rr=%0d round=%0d got=%b want=%b",
                         rr, r, ack_of(rr), 4'b0001 << exp);
            end
            set_irq(rr, exp, 1'b0);
            mpend[exp] = 1'b0;
            last = exp;
            tick();
            if (r < 8) begin
                lines = rr ? irq_rr : irq_fx;
                nw = 4'($urandom_range(0, 15)) & ~lines;
                mpend = mpend | nw;
                if (rr) irq_rr = irq_rr | nw; else irq_fx = irq_fx | nw;
            end
            tick(); tick(); tick();
            bus_write(base + 8'd3, 8'h00);
        end
        if (rr) last_rr = last;
        tick(); tick(); tick();
        checks++;
        if (raise_of(rr) !== 1'b0 || mpend !== 4'b0) begin
            errors++;
            $display("FAIL rand_drain rr=%0d raise=%b model=%b want=0/0000",
                     rr, raise_of(rr), mpend);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        logic seen;
        int n;
        irq_fx[1] = 1'b1;
        n = 0;
        while (!raise_fx && n < 20) begin tick(); n++; end
        checks++;
        if (raise_fx !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_timeout got=%b want=1", raise_fx);
        end
        cack_fx = 1'b1;
        RESET = 1'b1;
        #1;
        checks++;
        if (raise_fx !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_raise got=%b want=0", raise_fx);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_fx !== 4'b0) seen = 1'b1;
        end
        cack_fx = 1'b0;
        irq_fx = 4'b0;
        RESET = 1'b0;
        last_rr = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_fx !== 4'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_ack got=%b want=0", seen);
        end
        bus_read(FX + 8'd2, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_vector got=%h want=00", v);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        BUS_ADDR = 8'h00;
        BUS_WE = 1'b0;
        wdata = 8'h00;
        wen = 1'b0;
        irq_fx = 4'b0;
        irq_rr = 4'b0;
        cack_fx = 1'b0;
        cack_rr = 1'b0;
        test_reset();
        test_basic();
        test_fixed_prio();
        test_round_robin();
        test_mask_w1c();
        test_soft_trig();
        test_random(1'b0);
        test_random(1'b1);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
